// File: rtl/regfile_read_ctrl.sv
// Register-file read controller: latches a two-port read request,
// drives one-hot read enables for one cycle, captures with bypass.
module regfile_read_ctrl #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [AW-1:0]       src1,
  input  logic [AW-1:0]       src2,
  output logic [NUM_REGS-1:0] ReadEnable1,
  output logic [NUM_REGS-1:0] ReadEnable2,
  input  logic [DATA_W-1:0]   Bitline1,
  input  logic [DATA_W-1:0]   Bitline2,
  input  logic                wb_en,
  input  logic [AW-1:0]       wb_addr,
  input  logic [DATA_W-1:0]   wb_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rdata1,
  output logic [DATA_W-1:0]   rdata2
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    RESP
  } state_t;

  state_t            state;
  logic [AW-1:0]     a1;
  logic [AW-1:0]     a2;
  logic              hit1;
  logic              hit2;

  // Register 0 reads as zero, so its enable is never driven.
  function automatic logic [NUM_REGS-1:0] onehot(
    input logic [AW-1:0] a
  );
    logic [NUM_REGS-1:0] o;
    o    = '0;
    o[a] = (a != '0);
    return o;
  endfunction

  function automatic logic [DATA_W-1:0] pick(
    input logic [AW-1:0]     a,
    input logic              hit,
    input logic [DATA_W-1:0] bl,
    input logic [DATA_W-1:0] wd
  );
    logic [DATA_W-1:0] v;
    v = '0;
    unique case (1'b1)
      (a == '0):         v = '0;
      (a != '0) && hit:  v = wd;
      (a != '0) && !hit: v = bl;
    endcase
    return v;
  endfunction

  assign hit1 = wb_en && (wb_addr == a1) && (a1 != '0);
  assign hit2 = wb_en && (wb_addr == a2) && (a2 != '0);

  assign req_ready = (state == IDLE) ||
                     ((state == RESP) && rsp_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      a1          <= '0;
      a2          <= '0;
      rdata1      <= '0;
      rdata2      <= '0;
      rsp_valid   <= 1'b0;
      ReadEnable1 <= '0;
      ReadEnable2 <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            a1          <= src1;
            a2          <= src2;
            ReadEnable1 <= onehot(src1);
            ReadEnable2 <= onehot(src2);
            state       <= READ;
          end
        end
        READ: begin
          rdata1      <= pick(a1, hit1, Bitline1, wb_data);
          rdata2      <= pick(a2, hit2, Bitline2, wb_data);
          ReadEnable1 <= '0;
          ReadEnable2 <= '0;
          rsp_valid   <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (req_valid) begin
              a1          <= src1;
              a2          <= src2;
              ReadEnable1 <= onehot(src1);
              ReadEnable2 <= onehot(src2);
              state       <= READ;
            end else begin
              state <= IDLE;
            end
          end else begin
            // Keep held data coherent with writes to its registers.
            if (hit1) rdata1 <= wb_data;
            if (hit2) rdata2 <= wb_data;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_read_ctrl.sv
// Bench for regfile_read_ctrl: models a register array on the
// bitlines and checks responses against a spec-level model.
module tb_regfile_read_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  src1;
  logic [3:0]  src2;
  logic [15:0] ReadEnable1;
  logic [15:0] ReadEnable2;
  logic [15:0] Bitline1;
  logic [15:0] Bitline2;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rdata1;
  logic [15:0] rdata2;

  logic [15:0] regs [16];
  int checks = 0;
  int failures = 0;

  regfile_read_ctrl #(.DATA_W(16), .NUM_REGS(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .src1(src1), .src2(src2),
    .ReadEnable1(ReadEnable1), .ReadEnable2(ReadEnable2),
    .Bitline1(Bitline1), .Bitline2(Bitline2),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rdata1(rdata1), .rdata2(rdata2)
  );

  always #5 clk = ~clk;

  // Enabled register drives the shared bus; otherwise it floats.
  always_comb begin
    Bitline1 = 'x;
    Bitline2 = 'x;
    for (int i = 0; i < 16; i++) begin
      if (ReadEnable1[i]) Bitline1 = regs[i];
      if (ReadEnable2[i]) Bitline2 = regs[i];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (wb_en && wb_addr != 4'd0) regs[wb_addr] = wb_data;
  endtask

  function automatic logic [15:0] exp_en(int a);
    if (a == 0) return 16'h0000;
    return 16'(1) << a;
  endfunction

  function automatic logic [15:0] exp_rd(int a);
    if (a == 0) return 16'h0000;
    if (wb_en && int'(wb_addr) == a) return wb_data;
    return regs[a];
  endfunction

  task automatic test_reset();
    checks++;
    if (ReadEnable1 !== 16'h0 || ReadEnable2 !== 16'h0) begin
      failures++;
      $display("FAIL reset_en got=%h/%h exp=0000/0000",
               ReadEnable1, ReadEnable2);
    end
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_hs got v=%b r=%b exp v=0 r=1",
               rsp_valid, req_ready);
    end
    checks++;
    if (rdata1 !== 16'h0 || rdata2 !== 16'h0) begin
      failures++;
      $display("FAIL reset_rdata got=%h/%h exp=0000/0000",
               rdata1, rdata2);
    end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    regs[3] = 16'h1234;
    regs[7] = 16'hBEEF;
    req_valid = 1'b1; src1 = 4'd3; src2 = 4'd7;
    tick();
    req_valid = 1'b0; src1 = 4'd0; src2 = 4'd0;
    checks++;
    if (ReadEnable1 !== 16'h0008 || ReadEnable2 !== 16'h0080) begin
      failures++;
      $display("FAIL basic_en got=%h/%h exp=0008/0080",
               ReadEnable1, ReadEnable2);
    end
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_read_hs got r=%b v=%b exp r=0 v=0",
               req_ready, rsp_valid);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rdata1 !== 16'h1234 ||
        rdata2 !== 16'hBEEF) begin
      failures++;
      $display("FAIL basic_rsp got v=%b %h/%h exp v=1 1234/beef",
               rsp_valid, rdata1, rdata2);
    end
    checks++;
    if (ReadEnable1 !== 16'h0 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL basic_resp_en got en=%h r=%b exp en=0000 r=0",
               ReadEnable1, req_ready);
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_rdy_follow got=%b exp=1", req_ready);
    end
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_idle got v=%b r=%b exp v=0 r=1",
               rsp_valid, req_ready);
    end
  endtask

  task automatic test_zero();
    req_valid = 1'b1; src1 = 4'd0; src2 = 4'd0;
    tick();
    req_valid = 1'b0;
    wb_en = 1'b1; wb_addr = 4'd0; wb_data = 16'hFFFF;
    checks++;
    if (ReadEnable1 !== 16'h0 || ReadEnable2 !== 16'h0) begin
      failures++;
      $display("FAIL zero_en got=%h/%h exp=0000/0000",
               ReadEnable1, ReadEnable2);
    end
    tick();
    wb_en = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rdata1 !== 16'h0 ||
        rdata2 !== 16'h0) begin
      failures++;
      $display("FAIL zero_rsp got v=%b %h/%h exp v=1 0000/0000",
               rsp_valid, rdata1, rdata2);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_same_src();
    int a;
    logic [15:0] e;
    a = int'($urandom_range(1, 15));
    regs[a] = 16'($urandom);
    req_valid = 1'b1; src1 = 4'(a); src2 = 4'(a);
    tick();
    req_valid = 1'b0;
    checks++;
    if (ReadEnable1 !== exp_en(a) || ReadEnable2 !== exp_en(a)) begin
      failures++;
      $display("FAIL same_en got=%h/%h exp=%h", ReadEnable1,
               ReadEnable2, exp_en(a));
    end
    e = exp_rd(a);
    tick();
    checks++;
    if (rdata1 !== e || rdata2 !== e) begin
      failures++;
      $display("FAIL same_rd got=%h/%h exp=%h", rdata1, rdata2, e);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_bypass();
    logic [15:0] e2;
    regs[5] = 16'h0001;
    req_valid = 1'b1; src1 = 4'd5; src2 = 4'd9;
    tick();
    req_valid = 1'b0;
    wb_en = 1'b1; wb_addr = 4'd5; wb_data = 16'hA5A5;
    e2 = regs[9];
    tick();
    wb_en = 1'b0;
    checks++;
    if (rdata1 !== 16'hA5A5 || rdata2 !== e2) begin
      failures++;
      $display("FAIL bypass got=%h/%h exp=a5a5/%h",
               rdata1, rdata2, e2);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [15:0] e1, e2;
    regs[2] = 16'($urandom);
    regs[7] = 16'h7777;
    req_valid = 1'b1; src1 = 4'd2; src2 = 4'd7;
    tick();
    req_valid = 1'b0;
    tick();
    e1 = regs[2];
    e2 = regs[7];
    req_valid = 1'b1; src1 = 4'd4; src2 = 4'd6;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 ||
          rdata1 !== e1 || rdata2 !== e2) begin
        failures++;
        $display("FAIL bp_hold%0d got v=%b r=%b %h/%h exp v=1 r=0 %h/%h",
                 i, rsp_valid, req_ready, rdata1, rdata2, e1, e2);
      end
      tick();
    end
    wb_en = 1'b1; wb_addr = 4'd0; wb_data = 16'hFFFF;
    tick();
    checks++;
    if (rdata1 !== e1 || rdata2 !== e2) begin
      failures++;
      $display("FAIL bp_wb0 got=%h/%h exp=%h/%h",
               rdata1, rdata2, e1, e2);
    end
    wb_addr = 4'd7; wb_data = 16'h0F0F;
    tick();
    wb_en = 1'b0;
    checks++;
    if (rdata2 !== 16'h0F0F || rdata1 !== e1 ||
        rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_wb7 got v=%b %h/%h exp v=1 %h/0f0f",
               rsp_valid, rdata1, rdata2, e1);
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_rdy got=%b exp=1", req_ready);
    end
    tick();
    rsp_ready = 1'b0; req_valid = 1'b0;
    checks++;
    if (ReadEnable1 !== exp_en(4) || ReadEnable2 !== exp_en(6) ||
        rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_next_read got v=%b en=%h/%h exp v=0 %h/%h",
               rsp_valid, ReadEnable1, ReadEnable2,
               exp_en(4), exp_en(6));
    end
    e1 = exp_rd(4);
    e2 = exp_rd(6);
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rdata1 !== e1 || rdata2 !== e2) begin
      failures++;
      $display("FAIL bp_next_rsp got v=%b %h/%h exp v=1 %h/%h",
               rsp_valid, rdata1, rdata2, e1, e2);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int s1, s2;
    logic [15:0] e1, e2;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      s1 = int'($urandom_range(0, 15));
      s2 = ($urandom_range(0, 3) == 0) ? s1 :
           int'($urandom_range(0, 15));
      src1 = 4'(s1); src2 = 4'(s2);
      wb_en = 1'($urandom);
      wb_addr = 4'($urandom);
      wb_data = 16'($urandom);
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_rdy%0d got=%b exp=1", i, req_ready);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b0 || ReadEnable1 !== exp_en(s1) ||
          ReadEnable2 !== exp_en(s2)) begin
        failures++;
        $display("FAIL b2b_read%0d got v=%b %h/%h exp v=0 %h/%h",
                 i, rsp_valid, ReadEnable1, ReadEnable2,
                 exp_en(s1), exp_en(s2));
      end
      src1 = 4'($urandom); src2 = 4'($urandom);
      wb_en = 1'($urandom);
      wb_addr = ($urandom_range(0, 1) == 0) ? 4'(s1) : 4'($urandom);
      wb_data = 16'($urandom);
      e1 = exp_rd(s1);
      e2 = exp_rd(s2);
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rdata1 !== e1 || rdata2 !== e2) begin
        failures++;
        $display("FAIL b2b_rsp%0d got v=%b %h/%h exp v=1 %h/%h",
                 i, rsp_valid, rdata1, rdata2, e1, e2);
      end
    end
    req_valid = 1'b0;
    wb_en = 1'b0;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_end got v=%b r=%b exp v=0 r=1",
               rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] e1;
    req_valid = 1'b1; src1 = 4'd3; src2 = 4'd7;
    tick();
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (ReadEnable1 !== 16'h0 || ReadEnable2 !== 16'h0 ||
        rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_now got en=%h/%h v=%b r=%b exp 0/0 v=0 r=1",
               ReadEnable1, ReadEnable2, rsp_valid, req_ready);
    end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 ||
          rdata1 !== 16'h0) begin
        failures++;
        $display("FAIL rstmid_after%0d got v=%b r=%b d=%h exp v=0 r=1 d=0",
                 i, rsp_valid, req_ready, rdata1);
      end
    end
    regs[9] = 16'h5A5A;
    req_valid = 1'b1; src1 = 4'd9; src2 = 4'd0;
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rdata1 !== 16'h0) begin
      failures++;
      $display("FAIL rstresp got v=%b d=%h exp v=0 d=0000",
               rsp_valid, rdata1);
    end
    rst = 1'b1;
    regs[11] = 16'($urandom);
    req_valid = 1'b1; src1 = 4'd11; src2 = 4'd9;
    tick();
    req_valid = 1'b0;
    checks++;
    if (ReadEnable1 !== exp_en(11) || ReadEnable2 !== exp_en(9)) begin
      failures++;
      $display("FAIL rst_first_accept got=%h/%h exp=%h/%h",
               ReadEnable1, ReadEnable2, exp_en(11), exp_en(9));
    end
    e1 = exp_rd(11);
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rdata1 !== e1 ||
        rdata2 !== 16'h5A5A) begin
      failures++;
      $display("FAIL rst_first_rsp got v=%b %h/%h exp v=1 %h/5a5a",
               rsp_valid, rdata1, rdata2, e1);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0;
    src1 = 4'd0; src2 = 4'd0;
    rsp_ready = 1'b0;
    wb_en = 1'b0; wb_addr = 4'd0; wb_data = 16'h0;
    for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_zero();
    test_same_src();
    test_bypass();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_read_ctrl.md
REGFILE_READ_CTRL -- requirements
Module: regfile_read_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning bitline/data width per read port.
REQ-002 SHALL have parameter NUM_REGS, default 16, meaning register count (one-hot enable width); address width is log2(NUM_REGS) = 4.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid  input  1  read request valid.
REQ-006 SHALL have port req_ready  output  1  request accepted when req_valid and req_ready are both high at a rising edge.
REQ-007 SHALL have ports src1, src2  input  4  source register addresses.
REQ-008 SHALL have ports ReadEnable1, ReadEnable2  output  NUM_REGS  one-hot register read enables.
REQ-009 SHALL have ports Bitline1, Bitline2  input  DATA_W  shared read buses driven by enabled registers (high-Z when none enabled).
REQ-010 SHALL have ports wb_en (1), wb_addr (4), wb_data (DATA_W), all inputs  same-cycle register write, used for bypass.
REQ-011 SHALL have port rsp_valid  output  1  response data valid.
REQ-012 SHALL have port rsp_ready  input  1  consumer accepts response at rising edge when both high.
REQ-013 SHALL have ports rdata1, rdata2  output  DATA_W  read results for src1, src2.

Function
REQ-014 SHALL implement FSM states IDLE, READ, RESP.
REQ-015 IDLE: req_ready=1; on accept, latch src1/src2 into a1/a2 and go to READ; else stay.
REQ-016 READ: exactly one cycle; ReadEnableN = one-hot(aN), except bit 0 never asserted (aN=0 gives all-zero enable); at the edge, capture rdataN and go to RESP.
REQ-017 ReadEnable1/2 SHALL be all-zero in IDLE and RESP and SHALL come from registered state only (glitch-free, no combinational path from src inputs).
REQ-018 Capture value per port, in priority: aN=0 -> 0; wb_en and wb_addr=aN -> wb_data (bypass); else BitlineN.
REQ-019 RESP: rsp_valid=1; rdata held stable until accepted; req_ready = rsp_ready.
REQ-020 RESP with rsp_ready=1: if req_valid, latch new addresses and go to READ (one accepted request per 2 cycles); else go to IDLE.
REQ-021 RESP with rsp_ready=0 and wb_en, wb_addr=aN, aN!=0: rdataN SHALL update to wb_data at that edge (held data remains coherent).
REQ-022 src1=src2 SHALL yield identical rdata1/rdata2 with both enables asserting the same bit.
REQ-023 Request-to-rsp_valid latency SHALL be exactly 2 cycles (accept edge, READ edge).
REQ-024 wb_en with wb_addr=0 SHALL never affect any output.
REQ-025 Bitline X/Z values outside READ SHALL never propagate into rdata.

Reset
REQ-026 rst low SHALL asynchronously force state=IDLE, a1=a2=0, rdata1=rdata2=0, rsp_valid=0, ReadEnable1/2=0; req_ready=1 while in IDLE.
REQ-027 Reset asserted in READ or RESP SHALL abort the transaction with no response emitted; first accept is possible on the first edge after rst deasserts.

Verification
REQ-028 Basic read: R3=0x1234, R7=0xBEEF; request src1=3, src2=7 -> READ cycle ReadEnable1=0x0008, ReadEnable2=0x0080; next cycle rsp_valid=1, rdata1=0x1234, rdata2=0xBEEF.
REQ-029 Zero register: src1=0, src2=0 with Bitlines floating -> ReadEnables=0x0000, rdata1=rdata2=0x0000.
REQ-030 Bypass: R5=0x0001; during READ cycle wb_en=1, wb_addr=5, wb_data=0xA5A5, src1=5 -> rdata1=0xA5A5.
REQ-031 Backpressure: hold rsp_ready=0 for 4 cycles -> rsp_valid stays 1, rdata stable, req_ready=0; wb to held address 7 with 0x0F0F -> rdata2=0x0F0F; rsp_ready=1 with req_valid=1 -> next READ begins the following cycle.
REQ-032 Back-to-back: req_valid=1, rsp_ready=1 continuously -> rsp_valid pulses every other cycle, responses in request order.
REQ-033 Reset mid-transaction: assert rst low during READ -> outputs zero immediately, no rsp_valid after release, req_ready=1.
